// File: rtl/part_1_init_sync.sv
// Initiator-side co-simulation sync engine: snapshots the three channel vectors on each
// mission-clock rise, freezes the mission clock, streams the vectors and waits for the target reply.
module part_1_init_sync #(
  parameter int N        = 9,
  parameter int WATCHDOG = 10000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clk_0_h,
  input  logic         wen0,
  input  logic         wen1,
  input  logic         wen2,
  input  logic [7:0]   i_data0,
  input  logic [7:0]   i_data1,
  input  logic [7:0]   i_data2,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [1:0]   tx_idx,
  output logic [N-1:0] tx_data,
  input  logic         rx_valid,
  input  logic [1:0]   rx_idx,
  input  logic [N-1:0] rx_data,
  output logic         freeze_clk,
  output logic         valid,
  output logic [7:0]   o_data,
  output logic         upd,
  output logic         busy,
  output logic         wdog_err,
  output logic         proto_err,
  output logic         ovr_err
);

  localparam int WW = $clog2(WATCHDOG + 1);
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WATCHDOG - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              clk_0_h_dly_q, clk_0_h_dly_d;
  logic [2:0][N-1:0] snap_q, snap_d;
  logic [1:0]        idx_q, idx_d;
  logic              tx_valid_q, tx_valid_d;
  logic [N-1:0]      tx_data_q, tx_data_d;
  logic              freeze_q, freeze_d;
  logic              valid_q, valid_d;
  logic [7:0]        o_data_q, o_data_d;
  logic              upd_q, upd_d;
  logic              busy_q, busy_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              wdog_err_q, wdog_err_d;
  logic              proto_err_q, proto_err_d;
  logic              ovr_err_q, ovr_err_d;
  logic              rise_s;

  always_comb begin
    state_d       = state_q;
    clk_0_h_dly_d = clk_0_h;
    snap_d        = snap_q;
    idx_d         = idx_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    freeze_d      = freeze_q;
    valid_d       = valid_q;
    o_data_d      = o_data_q;
    upd_d         = 1'b0;
    wdog_d        = wdog_q;
    wdog_err_d    = wdog_err_q;
    proto_err_d   = proto_err_q;
    ovr_err_d     = ovr_err_q;
    rise_s        = clk_0_h & ~clk_0_h_dly_q;

    // A rise that arrives mid-transfer is dropped, not queued.
    if (rise_s && (state_q != IDLE)) begin
      ovr_err_d = 1'b1;
    end else begin
      ovr_err_d = ovr_err_q;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          proto_err_d = 1'b1;
        end else begin
          proto_err_d = proto_err_q;
        end
        if (rise_s) begin
          snap_d     = {{wen2, i_data2}, {wen1, i_data1}, {wen0, i_data0}};
          idx_d      = 2'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = {wen0, i_data0};
          freeze_d   = 1'b1;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (rx_valid) begin
          proto_err_d = 1'b1;
        end else begin
          proto_err_d = proto_err_q;
        end
        if (tx_ready) begin
          if (idx_q == 2'd2) begin
            idx_d      = 2'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            wdog_d     = '0;
            state_d    = WAIT_RSP;
          end else begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    tx_data_d = snap_q[1];
              default: tx_data_d = snap_q[2];
            endcase
          end
        end else begin
          state_d = SEND;
        end
      end
      WAIT_RSP: begin
        wdog_d = wdog_q + WDOG_ONE;
        // A response in the expiry cycle takes priority over the timeout.
        if (rx_valid && (rx_idx == 2'd3)) begin
          valid_d  = rx_data[N-1];
          o_data_d = rx_data[7:0];
          upd_d    = 1'b1;
          freeze_d = 1'b0;
          state_d  = IDLE;
        end else begin
          if (rx_valid) begin
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = proto_err_q;
          end
          if (wdog_q == WDOG_LAST) begin
            wdog_err_d = 1'b1;
            freeze_d   = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        freeze_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      clk_0_h_dly_q <= 1'b1;
      snap_q        <= '0;
      idx_q         <= 2'd0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      freeze_q      <= 1'b0;
      valid_q       <= 1'b0;
      o_data_q      <= 8'h00;
      upd_q         <= 1'b0;
      busy_q        <= 1'b0;
      wdog_q        <= '0;
      wdog_err_q    <= 1'b0;
      proto_err_q   <= 1'b0;
      ovr_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_0_h_dly_q <= clk_0_h_dly_d;
      snap_q        <= snap_d;
      idx_q         <= idx_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      freeze_q      <= freeze_d;
      valid_q       <= valid_d;
      o_data_q      <= o_data_d;
      upd_q         <= upd_d;
      busy_q        <= busy_d;
      wdog_q        <= wdog_d;
      wdog_err_q    <= wdog_err_d;
      proto_err_q   <= proto_err_d;
      ovr_err_q     <= ovr_err_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_idx     = idx_q;
  assign tx_data    = tx_data_q;
  assign freeze_clk = freeze_q;
  assign valid      = valid_q;
  assign o_data     = o_data_q;
  assign upd        = upd_q;
  assign busy       = busy_q;
  assign wdog_err   = wdog_err_q;
  assign proto_err  = proto_err_q;
  assign ovr_err    = ovr_err_q;

endmodule

// File: doc/part_1_init_sync.md
# part_1_init_sync

Initiator-side co-simulation sync engine, the counterpart of the target-side interface. On each rising edge of the mission clock `clk_0_h` it:
- snapshots the three SUT-input channel vectors `{wen, data}`;
- freezes the mission clock;
- streams the vectors to the transport over a valid/ready port;
- waits for the target's returned output vector `{valid, o_data}`, then releases the clock.

A watchdog bounds the wait.

## Interface
Parameters:
- `N`, 9, vector width: 1 enable/valid bit plus 8 data bits.
- `WATCHDOG`, 10000, cycles allowed in WAIT_RSP before timeout.

Ports:
- `clk_i` in 1: utility clock; all logic on its rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `clk_0_h` in 1: mission clock, synchronous to `clk_i`, sampled as data.
- `wen0`, `wen1`, `wen2` in 1 each: channel write enables.
- `i_data0`, `i_data1`, `i_data2` in 8 each: channel data.
- `tx_valid` out 1: transmit beat valid.
- `tx_ready` in 1: transport accepts beat.
- `tx_idx` out 2: channel index of beat (0..2).
- `tx_data` out N: `{wenK, i_dataK}`.
- `rx_valid` in 1: response beat from target.
- `rx_idx` in 2: response index; 3 = target output vector.
- `rx_data` in N: `{valid, o_data}` from target.
- `freeze_clk` out 1: 1 holds the mission clock.
- `valid` out 1, `o_data` out 8: last returned target outputs.
- `upd` out 1: one-cycle pulse when `valid`/`o_data` are refreshed.
- `busy` out 1: state ≠ IDLE.
- `wdog_err`, `proto_err`, `ovr_err` out 1 each: sticky error flags.

## Operation
- Edge detect:
  - `clk_0_h_d` registers `clk_0_h`; it resets to 1 so a high `clk_0_h` at reset release is not an edge.
  - `rise = clk_0_h & !clk_0_h_d`.
- IDLE:
  - on `rise`, capture `snap[k] = {wenk, i_datak}` for k = 0..2; set `idx = 0` and `freeze_clk = 1`; go to SEND.
- SEND:
  - drive `tx_valid = 1`, `tx_idx = idx`, `tx_data = snap[idx]`.
  - `tx_data` and `tx_idx` are stable while `tx_valid & !tx_ready`.
  - on `tx_ready`: if `idx == 2`, go to WAIT_RSP and clear the watchdog; else increment `idx`.
  - beats leave strictly in order 0, 1, 2.
- WAIT_RSP:
  - watchdog increments every cycle; counter width is `$clog2(WATCHDOG+1)`.
  - on `rx_valid & rx_idx == 3`: load `{valid, o_data} = rx_data`, pulse `upd`, clear `freeze_clk`, go to IDLE.
  - on `rx_valid & rx_idx != 3`: ignore the data, set `proto_err`, stay in WAIT_RSP.
  - when the counter reaches `WATCHDOG` with no response: set `wdog_err`, clear `freeze_clk`, go to IDLE; `valid`/`o_data` are unchanged and there is no `upd` pulse.
- `rx_valid` outside WAIT_RSP: ignored, sets `proto_err`.
- `rise` while not IDLE: the event is dropped (not queued) and `ovr_err` is set.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, any state): `tx_valid`, `tx_idx`, `tx_data`, `freeze_clk`, `valid`, `o_data`, `upd`, `busy`, and all error flags = 0; state IDLE; `clk_0_h_d` = 1.
- Reset mid-transfer: the transfer is aborted; no further beats after release.
- `rise` in cycle T:
  - `snap` captured at the end of T;
  - `freeze_clk`, `busy`, `tx_valid` high from T+1.
- With `tx_ready` held high: beats in T+1, T+2, T+3; WAIT_RSP from T+4.
- Earliest response in T+4: `valid`/`o_data`/`upd` update in T+5, `freeze_clk` = 0 in T+5, `busy` = 0 in T+5.
- `upd` is exactly one cycle wide.
- Response and watchdog expiry in the same cycle: the response wins; no `wdog_err`.
- Timeout: with no response, `wdog_err` rises and `freeze_clk` falls `WATCHDOG` cycles after entering WAIT_RSP.

## Test plan
- Basic frame:
  - stimulus: `wen0`=1, `i_data0`=0x11, `wen1`=0, `i_data1`=0x22, `wen2`=1, `i_data2`=0x33; `tx_ready`=1; `rise` at T; response `rx_idx`=3, `rx_data`=0x1A5 at T+4.
  - required: beats 0x111, 0x022, 0x133 with idx 0, 1, 2 in T+1..T+3; `valid`=1, `o_data`=0xA5, `upd` pulse at T+5.
- Backpressure:
  - stimulus: `tx_ready` low 4 cycles per beat.
  - required: each beat held stable until accepted; order unchanged; `freeze_clk` high throughout.
- Watchdog:
  - stimulus: `WATCHDOG`=20, no response.
  - required: `wdog_err`=1 and `freeze_clk`=0 20 cycles after entering WAIT_RSP; `o_data` retains its prior value.
- Protocol and overrun:
  - stimulus: `rx_valid` with `rx_idx`=1 during WAIT_RSP, and a second `rise` during SEND.
  - required: `proto_err`=1, `ovr_err`=1; the frame still completes on the `idx`=3 response.
- Reset mid-SEND:
  - stimulus: assert `rst_i` after beat 1 is accepted.
  - required: all outputs 0 immediately; after release, no beat until the next `rise`.
- Simultaneous response and timeout:
  - stimulus: response arrives in the expiry cycle.
  - required: `upd` pulses; `wdog_err` stays 0.
